// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the second-generation coprocessor 0.
//   - CP0 register addresses used by mtc0/mfc0
//   - exception codes the block reacts to
//   - bit positions of the SR and Cause fields
package cp0_pkg;

    // Register addresses
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field positions
    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned EXC_LO  = 2;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned IP_LO   = 10;
    localparam int unsigned TI_BIT  = 30;
    localparam int unsigned BD_BIT  = 31;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with clock prescaler.
//   clk, reset  : clock, synchronous active-high reset
//   count_we    : load Count from wdata and restart the prescaler
//   compare_we  : load Compare from wdata and clear ti
//   wdata       : mtc0 write data
//   count       : current Count value
//   compare     : current Compare value
//   ti          : sticky timer interrupt, set when Count steps onto Compare
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [31:0]   count_inc;

    assign tick      = (presc == PW'(COUNT_DIV - 1));
    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else if (tick) begin
                count <= count_inc;
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            // A Compare write clears ti even when a match lands in the same cycle;
            // a Count write suppresses the tick, so it can never set ti.
            if (compare_we)
                ti <= 1'b0;
            else if (!count_we && tick && (count_inc == compare))
                ti <= 1'b1;

            if (compare_we)
                compare <= wdata;
        end
    end

endmodule

// File: rtl/cp0_gen2.sv
// cp0_gen2: coprocessor 0 beside the M stage (SR, Cause, EPC, BadVAddr,
// Count/Compare timer, PRId).
//   clk, reset      : clock, synchronous active-high reset
//   en, CP0Addr     : mtc0 enable and register address (also the mfc0 address)
//   CP0In / CP0Out  : mtc0 write data / combinational mfc0 read data
//   VPC, BDin       : victim PC and delay-slot flag
//   ExcCodeIn       : exception code of the victim (0 = none)
//   BadVAddrIn      : faulting address, captured for AdEL/AdES
//   HWInt           : level-sensitive hardware interrupt lines
//   EXLClr          : eret retiring
//   Req             : take exception/interrupt this cycle (combinational)
//   EPCOut          : EPC forwarded to the fetch redirect (combinational)
//   TimerIrq        : registered timer interrupt (Cause.TI)
module cp0_gen2
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_HWINT  = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter int unsigned TIMER_LINE = 5,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4:0]           CP0Addr,
    input  logic [31:0]          CP0In,
    output logic [31:0]          CP0Out,
    input  logic [31:0]          VPC,
    input  logic                 BDin,
    input  logic [4:0]           ExcCodeIn,
    input  logic [31:0]          BadVAddrIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLClr,
    output logic                 Req,
    output logic [31:0]          EPCOut,
    output logic                 TimerIrq
);

    // SR fields
    logic [NUM_HWINT-1:0] im;
    logic                 exl;
    logic                 ie;

    // Cause fields
    logic                 bd;
    logic [4:0]           exc_code;
    logic [NUM_HWINT-1:0] cause_ip;

    logic [31:0]          epc;
    logic [31:0]          badvaddr;

    // Timer
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 ti;

    logic [NUM_HWINT-1:0] ipvec;
    logic                 int_req;
    logic                 exc_req;
    logic [31:0]          epc_next;
    logic [31:0]          sr_word;
    logic [31:0]          cause_word;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (en && (CP0Addr == CP0_COUNT)),
        .compare_we (en && (CP0Addr == CP0_COMPARE)),
        .wdata      (CP0In),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    assign ipvec    = HWInt | (NUM_HWINT'(ti) << TIMER_LINE);
    assign int_req  = (|(ipvec & im)) && !exl && ie;
    assign exc_req  = (ExcCodeIn != '0) && !exl;
    assign Req      = int_req || exc_req;
    assign epc_next = BDin ? (VPC - 32'd4) : VPC;
    assign EPCOut   = Req ? epc_next : epc;
    assign TimerIrq = ti;

    always_ff @(posedge clk) begin
        // IP tracks the live interrupt vector regardless of reset
        cause_ip <= ipvec;
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            if (en && (CP0Addr == CP0_SR)) begin
                im  <= CP0In[IM_LO +: NUM_HWINT];
                exl <= CP0In[EXL_BIT];
                ie  <= CP0In[IE_BIT];
            end
            if (en && (CP0Addr == CP0_EPC))
                epc <= CP0In;

            // Placed after the mtc0 writes so the exception entry overrides them
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? EXC_INT : ExcCodeIn;
                bd       <= BDin;
                epc      <= epc_next;
                if (!int_req && ((ExcCodeIn == EXC_ADEL) || (ExcCodeIn == EXC_ADES)))
                    badvaddr <= BadVAddrIn;
            end else if (EXLClr) begin
                exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_word                          = '0;
        sr_word[IM_LO +: NUM_HWINT]      = im;
        sr_word[EXL_BIT]                 = exl;
        sr_word[IE_BIT]                  = ie;

        cause_word                       = '0;
        cause_word[BD_BIT]               = bd;
        cause_word[TI_BIT]               = ti;
        cause_word[IP_LO +: NUM_HWINT]   = cause_ip;
        cause_word[EXC_LO +: 5]          = exc_code;
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Addr)
            CP0_BADVADDR: CP0Out = badvaddr;
            CP0_COUNT:    CP0Out = count;
            CP0_COMPARE:  CP0Out = compare;
            CP0_SR:       CP0Out = sr_word;
            CP0_CAUSE:    CP0Out = cause_word;
            CP0_EPC:      CP0Out = epc;
            CP0_PRID:     CP0Out = PRID_VAL;
            default:      CP0Out = '0;
        endcase
    end

endmodule
